// File: rtl/custom_down_counter.sv
// Loadable saturating down-counter with an IDLE/RUN/DONE sequence.
// It produces a one-cycle done pulse when the remaining count reaches zero.
module custom_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] step,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             at_zero,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state, w_nxt_state;
  logic [WIDTH-1:0] r_count, w_nxt_count;
  logic [WIDTH-1:0] w_eff_step;

  assign w_eff_step = (step == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : step;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_count <= w_nxt_count;
    end
  end

  // Priority is clear > load > en. A load restarts the countdown from any state.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_count = r_count;
    if (clear) begin
      w_nxt_state = IDLE;
      w_nxt_count = '0;
    end else if (load) begin
      w_nxt_count = load_value;
      w_nxt_state = (load_value != '0) ? RUN : DONE;
    end else begin
      case (r_state)
        IDLE: ;
        RUN: begin
          if (en) begin
            if (r_count > w_eff_step) begin
              w_nxt_count = r_count - w_eff_step;
            end else begin
              w_nxt_count = '0;
              w_nxt_state = DONE;
            end
          end
        end
        DONE:    w_nxt_state = IDLE;
        default: w_nxt_state = IDLE;
      endcase
    end
  end

  assign count   = r_count;
  assign at_zero = (r_count == '0);
  assign busy    = (r_state == RUN);
  assign done    = (r_state == DONE);

endmodule

// File: tb/tb_custom_down_counter.sv
// Directed bench for custom_down_counter.
// Inputs change 1 time unit after each rising edge, and outputs are checked at the same point.
module tb_custom_down_counter;

  logic       clk = 1'b0;
  logic       rstn, clear, load, en;
  logic [3:0] load_value, step;
  logic [3:0] count;
  logic       at_zero, busy, done;
  int         total = 0;
  int         bad = 0;

  custom_down_counter #(.WIDTH(4)) dut (
    .clk(clk), .rstn(rstn), .clear(clear), .load(load),
    .load_value(load_value), .step(step), .en(en),
    .count(count), .at_zero(at_zero), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Checks the full output set: count, busy, done, and at_zero derived from the expected count.
  task automatic chk_all(input string tag, input logic [3:0] c, input logic b, input logic d);
    chk({tag, ".count"}, count, c);
    chk({tag, ".busy"}, {3'b0, busy}, {3'b0, b});
    chk({tag, ".done"}, {3'b0, done}, {3'b0, d});
    chk({tag, ".at_zero"}, {3'b0, at_zero}, {3'b0, (c == 4'd0)});
  endtask

  initial begin
    rstn = 1'b0; clear = 1'b0; load = 1'b1; en = 1'b1;
    load_value = 4'd5; step = 4'd1;
    // 1. Reset: it overrides a simultaneous load.
    tick(); tick();
    chk_all("reset", 4'd0, 1'b0, 1'b0);
    rstn = 1'b1; load = 1'b0;
    tick();
    chk_all("idle_en_ignored", 4'd0, 1'b0, 1'b0);

    // 2. Basic countdown: 5,4,3,2,1,0 + done.
    load = 1'b1; load_value = 4'd5; step = 4'd1; en = 1'b1;
    tick(); load = 1'b0;
    chk_all("basic5", 4'd5, 1'b1, 1'b0);
    tick(); chk_all("basic4", 4'd4, 1'b1, 1'b0);
    tick(); chk_all("basic3", 4'd3, 1'b1, 1'b0);
    tick(); chk_all("basic2", 4'd2, 1'b1, 1'b0);
    en = 1'b0;
    tick(); chk_all("basic_hold", 4'd2, 1'b1, 1'b0);
    en = 1'b1;
    tick(); chk_all("basic1", 4'd1, 1'b1, 1'b0);
    tick(); chk_all("basic_done", 4'd0, 1'b0, 1'b1);
    tick(); chk_all("basic_idle", 4'd0, 1'b0, 1'b0);

    // 3. Saturation: 7,4,1,0 with step 3. The count must not wrap to 14.
    load = 1'b1; load_value = 4'd7; step = 4'd3;
    tick(); load = 1'b0;
    chk_all("sat7", 4'd7, 1'b1, 1'b0);
    tick(); chk_all("sat4", 4'd4, 1'b1, 1'b0);
    tick(); chk_all("sat1", 4'd1, 1'b1, 1'b0);
    tick(); chk_all("sat_done", 4'd0, 1'b0, 1'b1);
    tick(); chk_all("sat_idle", 4'd0, 1'b0, 1'b0);

    // 4. A step of 0 behaves as a step of 1.
    load = 1'b1; load_value = 4'd3; step = 4'd0;
    tick(); load = 1'b0;
    chk_all("s0_3", 4'd3, 1'b1, 1'b0);
    tick(); chk_all("s0_2", 4'd2, 1'b1, 1'b0);
    tick(); chk_all("s0_1", 4'd1, 1'b1, 1'b0);
    tick(); chk_all("s0_done", 4'd0, 1'b0, 1'b1);
    tick(); chk_all("s0_idle", 4'd0, 1'b0, 1'b0);

    // 5a. Loading 0 goes straight to done.
    load = 1'b1; load_value = 4'd0; step = 4'd1;
    tick(); load = 1'b0;
    chk_all("ld0_done", 4'd0, 1'b0, 1'b1);
    tick(); chk_all("ld0_idle", 4'd0, 1'b0, 1'b0);

    // 5b. Restart mid-run: load beats en.
    load = 1'b1; load_value = 4'd6;
    tick(); load = 1'b0;
    tick(); tick();
    chk_all("mid4", 4'd4, 1'b1, 1'b0);
    load = 1'b1; load_value = 4'd9; en = 1'b1;
    tick(); load = 1'b0; step = 4'd5;
    chk_all("restart9", 4'd9, 1'b1, 1'b0);
    tick(); chk_all("r9_4", 4'd4, 1'b1, 1'b0);
    tick(); chk_all("r9_done", 4'd0, 1'b0, 1'b1);

    // 5c. A load during the DONE cycle restarts instead of returning to IDLE.
    load = 1'b1; load_value = 4'd2; step = 4'd1;
    tick(); load = 1'b0;
    chk_all("done_ld2", 4'd2, 1'b1, 1'b0);
    tick(); chk_all("done_ld1", 4'd1, 1'b1, 1'b0);
    tick(); chk_all("done_ld_done", 4'd0, 1'b0, 1'b1);
    tick(); chk_all("done_ld_idle", 4'd0, 1'b0, 1'b0);

    // 6. Abort: clear beats load and en, and no done pulse follows.
    load = 1'b1; load_value = 4'd5;
    tick(); load = 1'b0;
    tick(); tick(); tick();
    chk_all("ab2", 4'd2, 1'b1, 1'b0);
    clear = 1'b1; load = 1'b1; load_value = 4'd7;
    tick(); clear = 1'b0; load = 1'b0;
    chk_all("abort", 4'd0, 1'b0, 1'b0);
    tick(); chk_all("abort_en1", 4'd0, 1'b0, 1'b0);
    tick(); chk_all("abort_en2", 4'd0, 1'b0, 1'b0);

    // Reset asserted during RUN returns to reset values with no done pulse.
    load = 1'b1; load_value = 4'd5;
    tick(); load = 1'b0;
    tick(); chk_all("rst_mid_pre", 4'd4, 1'b1, 1'b0);
    rstn = 1'b0;
    tick(); rstn = 1'b1;
    chk_all("rst_mid", 4'd0, 1'b0, 1'b0);
    tick(); chk_all("rst_mid_after", 4'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
